seven_segment_mux_gen: RTL and testbench
========================================

Name: seven_segment_mux_gen

Overview:
- Parametrised successor to the board's 4-digit hex display driver; time-multiplexes NUM_DIGITS common-anode digits.
- Adds:
  - load-strobed shadow register, so displayed data never tears mid-frame;
  - per-digit decimal points;
  - per-digit enables;
  - leading-zero suppression;
  - PWM brightness;
  - frame_tick output.
- Sits between the datapath/debug mux and the board's seven-segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits multiplexed (>=1).
- SLOT_LOG2, 17, each digit slot lasts 2^SLOT_LOG2 clocks.
- BRIGHT_W, 4, brightness control width (<= SLOT_LOG2).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- data_in, input, 4*NUM_DIGITS, hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost.
- dp_in, input, NUM_DIGITS, decimal-point request per digit (1 = lit).
- load, input, 1, single-cycle strobe that captures data_in/dp_in into the shadow register.
- blank_zero, input, 1, enables leading-zero suppression.
- digit_en, input, NUM_DIGITS, per-digit enable (0 forces digit dark).
- brightness, input, BRIGHT_W, duty control (0 = dimmest, all-ones = full on).
- seven_segment, output, 7, segments {a,b,c,d,e,f,g}, active low.
- dp, output, 1, decimal-point segment, active low.
- anode, output, NUM_DIGITS, digit select, active low, at most one bit low.
- frame_tick, output, 1, one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (async, immediate):
  - outputs: seven_segment=7'b1111111, dp=1, anode=all ones, frame_tick=0;
  - internal: shadow data/dp=0, slot counter=0, digit index=0.
- Shadow: on a clk edge with load=1, shadow_data<=data_in and shadow_dp<=dp_in. Otherwise it holds. Display logic reads the shadow only.
- Slot counter: SLOT_LOG2-bit, free-running, increments every clk, wraps naturally.
  - On the cycle the counter is all ones, the digit index advances. Index NUM_DIGITS-1 wraps to 0.
  - Index width = max(1, clog2(NUM_DIGITS)).
  - NUM_DIGITS=1: index stays 0.
- frame_tick: registered; high for exactly one cycle, the cycle after the index becomes 0 (period NUM_DIGITS*2^SLOT_LOG2).
- Decode: hex font 0-F, bit order {a..g}. Font, active low, digits 0-F:
  - 0000001 1001111 0010010 0000110 1001100 0100100 0100000 0001111
  - 0000000 0000100 0001000 1100000 0110001 1000010 0110000 0111000
- Suppression: when blank_zero=1, digit i>0 is suppressed iff shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
- PWM: phase = top BRIGHT_W bits of the slot counter. The digit is "on" iff phase <= brightness.
- Output rule for current index k, evaluated each cycle:
  - Dark: digit_en[k]=0, OR PWM off, OR (suppressed AND shadow_dp[k]=0) → anode all ones, segments 7'b1111111, dp=1.
  - Suppressed with dp set → anode[k]=0, segments 7'b1111111, dp=0.
  - Otherwise → anode[k]=0, segments=font(nibble k), dp=~shadow_dp[k].
- Outputs registered: they reflect the counter/index/shadow state of the previous cycle (latency 1 clk from any change, including load).
- Simultaneous load and index advance: the new shadow is used from the first cycle it is registered; no glitch mixing old and new nibbles within one output cycle.
- Input changes to brightness/digit_en/blank_zero take effect with the same 1-cycle latency.
- Reset mid-frame: outputs go to reset values asynchronously; after release, scanning restarts at digit 0 with counter 0.

Test Plan:
Bench parameters: NUM_DIGITS=4, SLOT_LOG2=4, BRIGHT_W=2.
1. Assert reset mid-run → seven_segment=7'b1111111, dp=1, anode=4'b1111, frame_tick=0 in the same cycle, before any clk edge.
2. load data_in=16'h12AF, dp_in=0, digit_en=4'hF, brightness=3, blank_zero=0 → repeating 16-cycle slots:
   - anode 1110/0111000, 1101/0001000, 1011/0010010, 0111/1001111;
   - frame_tick one cycle every 64.
3. Change data_in to 16'hFFFF without load → display unchanged. load pulse → new values appear 1 cycle after the capture edge.
4. load 16'h0005, dp_in=4'b0100, blank_zero=1:
   - digit0 shows 0100100;
   - digits 1 and 3: anode 1111;
   - digit2: anode 1011, segments 1111111, dp=0.
5. brightness=0 → each digit's anode is low for only 4 of its 16 cycles (the slot counter values 0-3). brightness=1 → low for 8 of 16.
6. digit_en=4'b1011 with 16'h12AF → slot 2 drives anode=4'b1111, segments 1111111; other slots as in scenario 2.

Source files
------------

// File: rtl/seven_segment_mux_gen_if.sv
// Display-side bundle for seven_segment_mux_gen: the datapath-facing
// controls (master) and the pin-facing outputs (driven by the slave).
interface seven_segment_mux_gen_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_zero;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [BRIGHT_W-1:0]     brightness;
    logic [6:0]              seven_segment;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_tick;

    modport master (
        output data_in, dp_in, load, blank_zero, digit_en, brightness,
        input  seven_segment, dp, anode, frame_tick
    );

    modport slave (
        input  data_in, dp_in, load, blank_zero, digit_en, brightness,
        output seven_segment, dp, anode, frame_tick
    );
endinterface

// File: rtl/seven_segment_mux_gen.sv
// Time-multiplexed common-anode hex display driver with shadow register,
// decimal points, digit enables, leading-zero blanking and PWM dimming.
module seven_segment_mux_gen #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_LOG2  = 17,
    parameter int BRIGHT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    seven_segment_mux_gen_if.slave   disp
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [SLOT_LOG2-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    tick_q, tick_d;

    logic [4*NUM_DIGITS-1:0] upper;
    logic [3:0]              nibble;
    logic [6:0]              font_seg;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    suppressed;
    logic                    pwm_on;

    always_comb begin
        shadow_data_d = disp.load ? disp.data_in : shadow_data_q;
        shadow_dp_d   = disp.load ? disp.dp_in   : shadow_dp_q;

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (&cnt_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        tick_d = (idx_q == '0) && (cnt_q == '0);

        // Shifting the shadow down to the current digit leaves exactly the
        // nibbles at and above it, so "all zero" is the suppression test.
        upper      = shadow_data_q >> {idx_q, 2'b00};
        nibble     = upper[3:0];
        cur_dp     = shadow_dp_q[idx_q];
        cur_en     = disp.digit_en[idx_q];
        suppressed = disp.blank_zero && (idx_q != '0) && (upper == '0);
        pwm_on     = cnt_q[SLOT_LOG2-1 -: BRIGHT_W] <= disp.brightness;

        case (nibble)
            4'h0: font_seg = 7'b0000001;
            4'h1: font_seg = 7'b1001111;
            4'h2: font_seg = 7'b0010010;
            4'h3: font_seg = 7'b0000110;
            4'h4: font_seg = 7'b1001100;
            4'h5: font_seg = 7'b0100100;
            4'h6: font_seg = 7'b0100000;
            4'h7: font_seg = 7'b0001111;
            4'h8: font_seg = 7'b0000000;
            4'h9: font_seg = 7'b0000100;
            4'hA: font_seg = 7'b0001000;
            4'hB: font_seg = 7'b1100000;
            4'hC: font_seg = 7'b0110001;
            4'hD: font_seg = 7'b1000010;
            4'hE: font_seg = 7'b0110000;
            default: font_seg = 7'b0111000;
        endcase

        anode_d = '1;
        seg_d   = '1;
        dp_d    = 1'b1;
        if (cur_en && pwm_on && !(suppressed && !cur_dp)) begin
            anode_d[idx_q] = 1'b0;
            if (suppressed) begin
                dp_d = 1'b0;
            end else begin
                seg_d = font_seg;
                dp_d  = ~cur_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            seg_q         <= '1;
            dp_q          <= 1'b1;
            anode_q       <= '1;
            tick_q        <= 1'b0;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            anode_q       <= anode_d;
            tick_q        <= tick_d;
        end
    end

    assign disp.seven_segment = seg_q;
    assign disp.dp            = dp_q;
    assign disp.anode         = anode_q;
    assign disp.frame_tick    = tick_q;
endmodule

// File: tb/tb_seven_segment_mux_gen.sv
// Scoreboard bench for seven_segment_mux_gen: per-edge expectations are
// derived from an edge count since reset release and the known shadow contents.
module tb_seven_segment_mux_gen;
    localparam int ND = 4;
    localparam int SL = 4;
    localparam int BW = 2;
    localparam logic [6:0] FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seven_segment_mux_gen_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) disp ();

    seven_segment_mux_gen #(
        .NUM_DIGITS(ND),
        .SLOT_LOG2 (SL),
        .BRIGHT_W  (BW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .disp (disp)
    );

    int   tests = 0;
    int   failed = 0;
    int   n = 0;
    exp_t sb [$];
    logic [15:0] sh_data = '0;
    logic [3:0]  sh_dp = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    // Expected outputs after edge m (m >= 1) counted from reset release.
    function automatic exp_t expect_at(int m);
        exp_t e;
        int c = (m - 1) % 16;
        int k = ((m - 1) / 16) % 4;
        logic [3:0] nib = sh_data[4*k +: 4];
        bit supp = 1'b0;
        bit on = (c / 4) <= int'(disp.brightness);
        if (disp.blank_zero && k > 0) begin
            supp = 1'b1;
            for (int j = k; j < 4; j++) if (sh_data[4*j +: 4] != 4'h0) supp = 1'b0;
        end
        e.anode = 4'hF;
        e.seg   = 7'h7F;
        e.dp    = 1'b1;
        e.tick  = ((m - 1) % 64) == 0;
        if (disp.digit_en[k] && on && !(supp && !sh_dp[k])) begin
            e.anode = ~(4'b0001 << k);
            if (supp) e.dp = 1'b0;
            else begin
                e.seg = FONT[nib];
                e.dp  = ~sh_dp[k];
            end
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g = {disp.anode, disp.seven_segment, disp.dp, disp.frame_tick};
        return g;
    endfunction

    task automatic test_reset();
        exp_t g;
        reset = 1'b1;
        #1;
        g = observed();
        tests++;
        if (g !== exp_t'({4'hF, 7'h7F, 1'b1, 1'b0})) begin
            failed++;
            $display("FAIL reset_init: got anode=%b seg=%b dp=%b tick=%b, want 1111/1111111/1/0",
                     g.anode, g.seg, g.dp, g.tick);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sh_data = '0;
        sh_dp = '0;
    endtask

    task automatic test_scan();
        exp_t e, g;
        int ticks = 0, first_tick = -1, second_tick = -1;
        disp.data_in = 16'h12AF; disp.dp_in = 4'h0; disp.digit_en = 4'hF;
        disp.brightness = 2'd3; disp.blank_zero = 1'b0; disp.load = 1'b1;
        for (int i = 0; i < 128; i++) begin
            sb.push_back(expect_at(n + 1));
            @(posedge clk);
            if (disp.load) begin sh_data = disp.data_in; sh_dp = disp.dp_in; end
            #1 disp.load = 1'b0;
            g = observed(); e = sb.pop_front(); tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL scan edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b",
                         n, g.anode, g.seg, g.dp, g.tick, e.anode, e.seg, e.dp, e.tick);
            end
            if (g.tick) begin
                ticks++;
                if (first_tick < 0) first_tick = n; else if (second_tick < 0) second_tick = n;
            end
        end
        tests++;
        if (ticks != 2 || second_tick - first_tick != 64) begin
            failed++;
            $display("FAIL frame_tick_period: got %0d ticks spacing %0d, want 2 ticks spacing 64",
                     ticks, second_tick - first_tick);
        end
    endtask

    task automatic test_no_tear();
        exp_t e, g;
        int align;
        disp.data_in = 16'hFFFF;
        align = 20 + (15 - (n + 20) % 16 + 16) % 16;
        for (int i = 0; i < align + 40; i++) begin
            if (i == align) disp.load = 1'b1;
            sb.push_back(expect_at(n + 1));
            @(posedge clk);
            if (disp.load) begin sh_data = disp.data_in; sh_dp = disp.dp_in; end
            #1 disp.load = 1'b0;
            g = observed(); e = sb.pop_front(); tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL no_tear edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b",
                         n, g.anode, g.seg, g.dp, g.tick, e.anode, e.seg, e.dp, e.tick);
            end
        end
    endtask

    task automatic test_blank();
        exp_t e, g;
        int dp_low = 0;
        disp.data_in = 16'h0005; disp.dp_in = 4'b0100; disp.blank_zero = 1'b1;
        disp.load = 1'b1;
        for (int i = 0; i < 72; i++) begin
            sb.push_back(expect_at(n + 1));
            @(posedge clk);
            if (disp.load) begin sh_data = disp.data_in; sh_dp = disp.dp_in; end
            #1 disp.load = 1'b0;
            g = observed(); e = sb.pop_front(); tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL blank edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b",
                         n, g.anode, g.seg, g.dp, g.tick, e.anode, e.seg, e.dp, e.tick);
            end
            if (i >= 8 && !g.dp) dp_low++;
        end
        tests++;
        if (dp_low != 16) begin
            failed++;
            $display("FAIL blank_dp_count: got %0d cycles with dp lit, want 16", dp_low);
        end
        disp.blank_zero = 1'b0;
    endtask

    task automatic test_digit_en();
        exp_t e, g;
        disp.data_in = 16'h12AF; disp.dp_in = 4'h0; disp.digit_en = 4'b1011;
        disp.load = 1'b1;
        for (int i = 0; i < 70; i++) begin
            sb.push_back(expect_at(n + 1));
            @(posedge clk);
            if (disp.load) begin sh_data = disp.data_in; sh_dp = disp.dp_in; end
            #1 disp.load = 1'b0;
            g = observed(); e = sb.pop_front(); tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL digit_en edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b",
                         n, g.anode, g.seg, g.dp, g.tick, e.anode, e.seg, e.dp, e.tick);
            end
        end
        disp.digit_en = 4'hF;
    endtask

    task automatic test_pwm();
        exp_t e, g;
        int lit;
        for (int b = 0; b < 2; b++) begin
            disp.brightness = BW'(b);
            lit = 0;
            for (int i = 0; i < 64; i++) begin
                sb.push_back(expect_at(n + 1));
                @(posedge clk);
                #1;
                g = observed(); e = sb.pop_front(); tests++;
                if (g !== e) begin
                    failed++;
                    $display("FAIL pwm%0d edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b",
                             b, n, g.anode, g.seg, g.dp, g.tick, e.anode, e.seg, e.dp, e.tick);
                end
                if (g.anode != 4'hF) lit++;
            end
            tests++;
            if (lit != 16 * (b + 1)) begin
                failed++;
                $display("FAIL pwm%0d_duty: got %0d lit cycles per frame, want %0d", b, lit, 16 * (b + 1));
            end
        end
        disp.brightness = 2'd3;
    endtask

    task automatic test_reset_mid();
        exp_t e, g;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(expect_at(n + 1));
            @(posedge clk);
            #1;
            g = observed(); e = sb.pop_front(); tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL pre_reset edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b",
                         n, g.anode, g.seg, g.dp, g.tick, e.anode, e.seg, e.dp, e.tick);
            end
        end
        #2 reset = 1'b1;
        #1;
        g = observed(); tests++;
        if (g !== exp_t'({4'hF, 7'h7F, 1'b1, 1'b0})) begin
            failed++;
            $display("FAIL reset_async: got anode=%b seg=%b dp=%b tick=%b, want 1111/1111111/1/0",
                     g.anode, g.seg, g.dp, g.tick);
        end
        @(negedge clk);
        reset = 1'b0;
        sh_data = '0;
        sh_dp = '0;
        for (int i = 0; i < 24; i++) begin
            sb.push_back(expect_at(n + 1));
            @(posedge clk);
            #1;
            g = observed(); e = sb.pop_front(); tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL post_reset edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b",
                         n, g.anode, g.seg, g.dp, g.tick, e.anode, e.seg, e.dp, e.tick);
            end
        end
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        disp.data_in = '0; disp.dp_in = '0; disp.load = 1'b0; disp.blank_zero = 1'b0;
        disp.digit_en = 4'hF; disp.brightness = 2'd3;
        #1;
        test_reset();
        test_scan();
        test_no_tear();
        test_blank();
        test_digit_en();
        test_pwm();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
